// File: rtl/imem_loader.sv
// UART boot loader: assembles a length-prefixed image into 32-bit words
// and writes them into instruction memory, holding the core in reset.
module imem_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int WORD = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rxd,
  output logic        we,
  output logic [31:0] addr,
  output logic [31:0] data,
  output logic        proc_rst,
  output logic        done,
  output logic        err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [31:0] WMAX = 32'(WORD);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [2:0] LEN0 = 3'd0;
  localparam logic [2:0] LEN1 = 3'd1;
  localparam logic [2:0] BODY = 3'd2;
  localparam logic [2:0] DONE = 3'd3;
  localparam logic [2:0] ERR  = 3'd4;

  logic          rx1;
  logic          rxs;
  logic [1:0]    bst;
  logic [CW-1:0] cnt;
  logic [2:0]    nbit;
  logic [7:0]    sh;
  logic [7:0]    rbyte;
  logic          byte_v;
  logic          tick;
  logic          frame_err;
  logic [2:0]    pst;
  logic [15:0]   len;
  logic [1:0]    idx;
  logic [15:0]   nlen;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx1 <= 1'b1;
      rxs <= 1'b1;
    end else begin
      rx1 <= rxd;
      rxs <= rx1;
    end
  end

  assign tick = (cnt == ONE);
  assign frame_err = (bst == STOP) && tick && !rxs;

  always_ff @(posedge clk) begin
    if (rst) begin
      bst    <= IDLE;
      cnt    <= '0;
      nbit   <= '0;
      sh     <= '0;
      rbyte  <= '0;
      byte_v <= 1'b0;
    end else begin
      byte_v <= 1'b0;
      unique case (bst)
        IDLE: begin
          if (!rxs) begin
            bst <= START;
            cnt <= HALF;
          end
        end
        START: begin
          if (tick) begin
            if (!rxs) begin
              bst  <= DATA;
              cnt  <= FULL;
              nbit <= '0;
            end else begin
              bst <= IDLE;
            end
          end else begin
            cnt <= cnt - ONE;
          end
        end
        DATA: begin
          if (tick) begin
            sh   <= {rxs, sh[7:1]};
            cnt  <= FULL;
            nbit <= nbit + 3'd1;
            if (nbit == 3'd7) bst <= STOP;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        STOP: begin
          if (tick) begin
            bst <= IDLE;
            if (rxs) begin
              byte_v <= 1'b1;
              rbyte  <= sh;
            end
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: bst <= IDLE;
      endcase
    end
  end

  assign nlen = {rbyte, len[7:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      pst  <= LEN0;
      len  <= '0;
      idx  <= '0;
      addr <= '0;
      data <= '0;
      we   <= 1'b0;
    end else begin
      we <= 1'b0;
      unique case (pst)
        LEN0: begin
          if (frame_err) begin
            pst <= ERR;
          end else if (byte_v) begin
            len[7:0] <= rbyte;
            pst      <= LEN1;
          end
        end
        LEN1: begin
          if (frame_err) begin
            pst <= ERR;
          end else if (byte_v) begin
            len[15:8] <= rbyte;
            if (nlen == 16'd0) pst <= DONE;
            else if ({16'd0, nlen} > WMAX) pst <= ERR;
            else pst <= BODY;
          end
        end
        BODY: begin
          if (frame_err) begin
            pst <= ERR;
          end else begin
            // addr holds through the pulse; the last word never bumps it
            if (we) begin
              if (addr + 32'd1 == {16'd0, len}) pst <= DONE;
              else addr <= addr + 32'd1;
            end
            if (byte_v) begin
              data[{idx, 3'b000} +: 8] <= rbyte;
              idx <= idx + 2'd1;
              if (idx == 2'd3) we <= 1'b1;
            end
          end
        end
        DONE: ;
        ERR: ;
        default: pst <= ERR;
      endcase
    end
  end

  assign done = (pst == DONE);
  assign err = (pst == ERR);
  assign proc_rst = !done;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized UART image loads checked against a
// byte-stream reference model of the loader protocol.
module tb_imem_loader;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic        we;
  logic [31:0] addr;
  logic [31:0] data;
  logic        proc_rst;
  logic        done;
  logic        err;

  int n_chk = 0;
  int n_fail = 0;

  logic [63:0] obs[$];
  int cyc = 0;
  int last_we = -1;
  int done_rise = -1;
  logic done_q = 1'b0;

  imem_loader #(.CLKS_PER_BIT(CPB), .WORD(4096)) dut (
    .clk(clk),
    .rst(rst),
    .rxd(rxd),
    .we(we),
    .addr(addr),
    .data(data),
    .proc_rst(proc_rst),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      obs.delete();
      last_we = -1;
      done_rise = -1;
    end else begin
      if (we) begin
        obs.push_back({addr, data});
        last_we = cyc;
      end
      if (done && !done_q) done_rise = cyc;
    end
    done_q = done;
  end

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    n_chk++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ":we"}, 64'(we), 64'd0);
    chk({tag, ":addr"}, 64'(addr), 64'd0);
    chk({tag, ":data"}, 64'(data), 64'd0);
    chk({tag, ":proc_rst"}, 64'(proc_rst), 64'd1);
    chk({tag, ":done"}, 64'(done), 64'd0);
    chk({tag, ":err"}, 64'(err), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic bit_time(input logic v);
    rxd = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input bit ok);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(ok);
    rxd = 1'b1;
  endtask

  task automatic load(input logic [7:0] q[$], input int bad,
                      input bit pre_rst, input string tag);
    logic [63:0] ew[$];
    logic [31:0] w;
    bit ed;
    bit ee;
    int n;
    ed = 0;
    ee = 0;
    w = '0;
    n = (q.size() >= 2) ? int'({q[1], q[0]}) : -1;
    for (int i = 0; i < q.size(); i++) begin
      if (ed || ee) break;
      if (i == bad) begin
        ee = 1;
        break;
      end
      if (i == 1) begin
        if (n == 0) ed = 1;
        else if (n > 4096) ee = 1;
      end else if (i >= 2) begin
        w[8*((i-2)%4) +: 8] = q[i];
        if ((i - 2) % 4 == 3) begin
          ew.push_back({32'(ew.size()), w});
          if (ew.size() == n) ed = 1;
        end
      end
    end
    if (pre_rst) do_reset();
    for (int i = 0; i < q.size(); i++) begin
      send(q[i], i != bad);
      repeat ($urandom_range(0, 2) * CPB) @(negedge clk);
    end
    repeat (3 * CPB) @(negedge clk);
    chk({tag, ":nwe"}, 64'(obs.size()), 64'(ew.size()));
    for (int i = 0; i < ew.size() && i < obs.size(); i++)
      chk($sformatf("%s:w%0d", tag, i), obs[i], ew[i]);
    chk({tag, ":done"}, 64'(done), 64'(ed));
    chk({tag, ":err"}, 64'(err), 64'(ee));
    chk({tag, ":proc_rst"}, 64'(proc_rst), 64'(!ed));
    if (ed && ew.size() > 0)
      chk({tag, ":release"}, 64'(done_rise), 64'(last_we + 1));
  endtask

  initial begin
    logic [7:0] q[$];
    int nw;
    int bad;

    do_reset();
    chk_reset_vals("reset");

    q = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12,
          8'hEF, 8'hBE, 8'hAD, 8'hDE};
    load(q, -1, 1, "two_word");

    q = '{8'h00, 8'h00};
    load(q, -1, 1, "empty");

    q = '{8'h01, 8'h00, 8'h11, 8'h55, 8'h66, 8'h77};
    load(q, 3, 1, "framing");

    q = '{8'h01, 8'h10, 8'h00, 8'h00};
    load(q, -1, 1, "oversize");

    q = '{8'h00, 8'h00, 8'h55};
    load(q, 2, 1, "done_ignores");

    q = '{8'h01, 8'h00, 8'hAA, 8'hBB};
    load(q, -1, 1, "mid_a");
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    @(negedge clk);
    rst = 1'b1;
    rxd = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("mid_rst");
    q = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04};
    load(q, -1, 0, "mid_b");

    do_reset();
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    chk("glitch:done", 64'(done), 64'd0);
    chk("glitch:err", 64'(err), 64'd0);
    q = '{8'h01, 8'h00, 8'hC3, 8'hB2, 8'hA1, 8'h90};
    load(q, -1, 0, "glitch_load");

    for (int r = 0; r < 6; r++) begin
      nw = $urandom_range(1, 4);
      q.delete();
      q.push_back(8'(nw));
      q.push_back(8'h00);
      for (int i = 0; i < 4 * nw; i++) q.push_back(8'($urandom));
      bad = (r == 5) ? $urandom_range(2, q.size() - 1) : -1;
      load(q, bad, 1, $sformatf("rnd%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Serial boot loader that sits upstream of the processor core and its 4096-word instruction memory. It receives a program image over a UART RX line and assembles little-endian 32-bit words. It writes each word into instruction memory through a single write port. It holds the core in reset until the image is complete, then releases it; on any protocol error it keeps the core in reset and flags the error.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200); must be ≥ 4.
- `WORD`, default 4096: instruction memory depth in words.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high; clock `clk`.
- `rxd`  in  1  UART receive line; asynchronous; idle high; 8N1 format, LSB first.
- `we`  out  1  imem write enable; one-cycle pulse per word.
- `addr`  out  32  imem word address; upper bits are always 0.
- `data`  out  32  imem write data.
- `proc_rst`  out  1  reset to the processor core; high until the load is complete.
- `done`  out  1  image fully written; sticky until `rst`.
- `err`  out  1  protocol error; sticky until `rst`.

## Operation
- **Reset values.** `we=0`, `addr=0`, `data=0`, `proc_rst=1`, `done=0`, `err=0`, all FSMs idle.
- **RX synchronizer.** `rxd` passes through a 2-flop synchronizer, reset to 1. All logic uses the synchronized value `rxs`.
- **Bit FSM states:** `IDLE`, `START`, `DATA`, `STOP`.
  - `IDLE` → `START` when `rxs`=0; a bit counter is loaded with `CLKS_PER_BIT/2`.
  - `START`: at count expiry, if `rxs`=0 go to `DATA` with the counter set to `CLKS_PER_BIT`. Otherwise the start was a glitch: return to `IDLE` with no byte and no error.
  - `DATA`: sample 8 bits, one every `CLKS_PER_BIT` cycles, shifted in LSB first.
  - `STOP`: sample once. If `rxs`=1, the byte is accepted and `byte_v` pulses for one cycle. If `rxs`=0, this is a framing error and `err` is set. Both cases return to `IDLE`.
- **Protocol FSM states:** `LEN0`, `LEN1`, `BODY`, `DONE`, `ERR`.
  - `LEN0` / `LEN1`: capture the 16-bit word count N, little-endian (low byte first).
  - After `LEN1`:
    - N=0 → `DONE`.
    - N>`WORD` → `ERR`.
    - Otherwise → `BODY`.
  - `BODY`: a 2-bit byte index places byte k at `data[8k+:8]`. On the 4th byte, `we` pulses with the full word and `addr` set to the current word index. `addr` increments the cycle after the pulse.
  - When N words have been written → `DONE`.
  - `DONE`: `done`=1, `proc_rst`=0. Further RX bytes are ignored, and so are framing errors.
  - `ERR`: `err`=1, `proc_rst`=1, `we` is never asserted. Only `rst` exits this state.
- **Address width.** `addr` spans at most 0…`WORD`−1 and never wraps, because N≤`WORD` is enforced before `BODY`.
- **Reset mid-load.** `rst` mid-load aborts the transfer. All outputs return to reset values the next cycle. A partially received byte is discarded. Words already written are not cleared.
- **Write-port ownership.** The write port owns imem only while `proc_rst`=1. The integrator muxes imem `addr` to the core PC when `proc_rst`=0.

## Timing
- **Sample point.** Each bit is sampled `CLKS_PER_BIT/2` cycles after its nominal edge, measured from the synchronized falling edge of the start bit. Synchronizer latency is 2 cycles.
- **Byte strobe.** `byte_v` is asserted 1 cycle after the stop-bit sample.
- **Write pulse.** `we` is asserted 1 cycle after the `byte_v` of the 4th byte of each word. `data` and `addr` are stable that cycle.
- **Release.** `done` rises and `proc_rst` falls together, 1 cycle after the last `we`. For N=0 this happens 1 cycle after the `LEN1` `byte_v`.
- **Error.** `err` rises 1 cycle after the failing stop-bit sample, or 1 cycle after the `LEN1` `byte_v` when N>`WORD`.
- **Spacing.** Back-to-back frames with zero idle time between stop and the next start are supported.
- **Tolerance.** Sender baud error up to ±2% is tolerated.

## Test plan
- **Two-word load.** `CLKS_PER_BIT`=8; send `02 00 78 56 34 12 EF BE AD DE` → `we` pulses twice with (addr 0, `0x12345678`) then (addr 1, `0xDEADBEEF`); `done`=1 and `proc_rst`=0 one cycle after the second pulse.
- **Empty image.** Send `00 00` → no `we`; `done`=1 one cycle after the 2nd byte strobe; `err`=0.
- **Framing error.** Send `01 00 11`, then a byte whose stop bit is held low → `err`=1; `proc_rst` stays 1; no `we` follows.
- **Oversized count.** Send `01 10` (N=4097) → `err`=1; no `we`. Then send `00 00` → state unchanged.
- **Reset mid-load.** Send `01 00 AA BB`, assert `rst` for 1 cycle, then send `01 00 01 02 03 04` → exactly one `we`, at (addr 0, `0x04030201`); `done`=1.
- **Glitch rejection.** Drive a 2-cycle low pulse on `rxd` in `IDLE` (shorter than `CLKS_PER_BIT/2`) → no byte strobe; no error. A following valid load completes normally.
